// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register.
// Runs one req/ack data-memory transaction per load/store and holds `ready` low until it completes.
module mem_wb_stage #(
    parameter int unsigned ADDR_BASE = 1024,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_res,
    input  logic [31:0] st_val,
    input  logic [3:0]  dest,
    output logic        ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] wb_result,
    output logic [3:0]  wb_dest,
    output logic        wb_en,
    output logic        mem_err
);

    localparam logic [31:0] BASE    = 32'(ADDR_BASE);
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] BAD_RD  = 32'hDEADBEEF;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_bus_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [31:0] rdata, rdata_nxt;
    logic        err_nxt;
    mem_bus_t    bus, bus_nxt;

    logic        mem_op;
    logic [31:0] addr_off;
    logic [31:0] word_addr;

    // A simultaneous read+write request is treated as a plain read.
    assign mem_op    = mem_r_en | mem_w_en;
    assign addr_off  = alu_res - BASE;
    assign word_addr = addr_off >> 2;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdata_nxt = rdata;
        err_nxt   = mem_err;
        bus_nxt   = bus;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = !mem_op;
                if (mem_op) begin
                    state_nxt     = ACCESS;
                    bus_nxt.req   = 1'b1;
                    bus_nxt.we    = mem_w_en & !mem_r_en;
                    bus_nxt.addr  = word_addr;
                    bus_nxt.wdata = st_val;
                    cnt_nxt       = 8'd0;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_nxt   = DONE;
                    bus_nxt.req = 1'b0;
                    bus_nxt.we  = 1'b0;
                    rdata_nxt   = mem_rdata;
                end else if (cnt == TO_LAST) begin
                    // Abandon the access; a poisoned value goes to write-back.
                    state_nxt   = DONE;
                    bus_nxt.req = 1'b0;
                    rdata_nxt   = BAD_RD;
                    err_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            rdata   <= 32'd0;
            mem_err <= 1'b0;
            bus     <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata   <= rdata_nxt;
            mem_err <= err_nxt;
            bus     <= bus_nxt;
        end
    end

    assign mem_req   = bus.req;
    assign mem_we    = bus.we;
    assign mem_addr  = bus.addr;
    assign mem_wdata = bus.wdata;

    // MEM/WB register: a stalled cycle inserts a bubble but keeps the last result visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en     <= 1'b0;
            wb_dest   <= 4'd0;
            wb_result <= 32'd0;
        end else if (ready) begin
            wb_en     <= wb_en_in;
            wb_dest   <= dest;
            wb_result <= mem_r_en ? rdata : alu_res;
        end else begin
            wb_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table of ALU ops, directed memory sequences and a randomized
// run checked against a transaction-level latency/result model.
module tb_mem_wb_stage;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en_in = 1'b0, mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [31:0] alu_res = '0, st_val = '0;
    logic [3:0]  dest = '0;
    logic        ready, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] wb_result;
    logic [3:0]  wb_dest;
    logic        wb_en, mem_err;

    int checks = 0;
    int errors = 0;
    logic model_err = 1'b0;

    mem_wb_stage #(.ADDR_BASE(1024), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_res(alu_res), .st_val(st_val), .dest(dest), .ready(ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_result(wb_result), .wb_dest(wb_dest), .wb_en(wb_en),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one instruction at a negedge and follow it to retirement. Memory acks in the
    // k-th ACCESS cycle; k > TIMEOUT means it never acks.
    task automatic run_op(input logic wi, input logic r, input logic w, input logic [31:0] alu,
                          input logic [31:0] st, input logic [3:0] dst, input int k,
                          input logic [31:0] rd, input string tag);
        int low, reqc, wbc, cyc, acc;
        logic rdy, mem;
        logic [31:0] eres;
        low = 0; reqc = 0; wbc = 0; cyc = 0;
        mem  = r | w;
        acc  = (k <= TIMEOUT) ? k : TIMEOUT;
        eres = r ? ((k <= TIMEOUT) ? rd : 32'hDEADBEEF) : alu;
        if (mem && k > TIMEOUT) model_err = 1'b1;
        wb_en_in = wi; mem_r_en = r; mem_w_en = w;
        alu_res = alu; st_val = st; dest = dst; mem_ack = 1'b0;
        while (1) begin
            #1 rdy = ready;
            if (!rdy) low++;
            if (mem_req) begin
                reqc++;
                if (reqc == 1) begin
                    check({tag, " addr"}, mem_addr, (alu - 32'd1024) >> 2);
                    check({tag, " we"}, 32'(mem_we), 32'(w & !r));
                    check({tag, " wdata"}, mem_wdata, st);
                end
                mem_ack   = (reqc == k);
                mem_rdata = mem_ack ? rd : $urandom;
            end else begin
                mem_ack = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (wb_en) wbc++;
            cyc++;
            if (rdy) break;
            if (cyc > 40) begin
                checks++; errors++;
                $display("FAIL %s bound: ready stuck low after %0d cycles, required retire", tag, cyc);
                break;
            end
        end
        mem_ack = 1'b0;
        check({tag, " stall"}, low, mem ? acc + 1 : 0);
        check({tag, " req_cycles"}, reqc, mem ? acc : 0);
        check({tag, " wb_en_cycles"}, wbc, 32'(wi));
        check({tag, " wb_result"}, wb_result, eres);
        check({tag, " wb_dest"}, 32'(wb_dest), 32'(dst));
        check({tag, " mem_err"}, 32'(mem_err), 32'(model_err));
    endtask

    typedef struct {
        logic        wi;
        logic [31:0] alu;
        logic [3:0]  dst;
        logic [31:0] eres;
        logic [3:0]  edst;
        logic        een;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{1'b1, 32'h0000_1234, 4'd3,  32'h0000_1234, 4'd3,  1'b1};
        vt[1] = '{1'b0, 32'hFFFF_FFFF, 4'd15, 32'hFFFF_FFFF, 4'd15, 1'b0};
        vt[2] = '{1'b1, 32'h0000_0000, 4'd0,  32'h0000_0000, 4'd0,  1'b1};
        vt[3] = '{1'b1, 32'h8000_0001, 4'd9,  32'h8000_0001, 4'd9,  1'b1};
        vt[4] = '{1'b1, 32'h0000_0400, 4'd7,  32'h0000_0400, 4'd7,  1'b1};

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst mem_req", 32'(mem_req), 0);
        check("rst mem_we", 32'(mem_we), 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst wb_result", wb_result, 0);
        check("rst wb_dest", 32'(wb_dest), 0);
        check("rst wb_en", 32'(wb_en), 0);
        check("rst mem_err", 32'(mem_err), 0);
        check("rst ready", 32'(ready), 1);
        rst = 1'b0;

        // Non-memory ops: one cycle, no stall, no request
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wb_en_in = vt[i].wi; alu_res = vt[i].alu; dest = vt[i].dst;
            mem_r_en = 1'b0; mem_w_en = 1'b0;
            #1;
            check($sformatf("alu%0d ready", i), 32'(ready), 1);
            @(posedge clk);
            #1;
            check($sformatf("alu%0d mem_req", i), 32'(mem_req), 0);
            check($sformatf("alu%0d wb_result", i), wb_result, vt[i].eres);
            check($sformatf("alu%0d wb_dest", i), 32'(wb_dest), 32'(vt[i].edst));
            check($sformatf("alu%0d wb_en", i), 32'(wb_en), 32'(vt[i].een));
        end
        @(negedge clk);

        // Directed memory sequences
        run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd5, 3, 32'hCAFE0001, "load");
        run_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'h55AA, 4'd2, 1, 32'h0, "store");
        run_op(1'b1, 1'b1, 1'b1, 32'd1040, 32'h1111, 4'd4, 2, 32'h0BAD_F00D, "rdwr");
        run_op(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd6, 1000, 32'h0, "timeout");
        run_op(1'b1, 1'b0, 1'b0, 32'h0000_00AB, 32'h0, 4'd1, 0, 32'h0, "after_to");
        run_op(1'b1, 1'b1, 1'b0, 32'd1044, 32'h0, 4'd8, 2, 32'h1234_5678, "b2b_ld");
        run_op(1'b1, 1'b0, 1'b0, 32'h0000_0777, 32'h0, 4'd9, 0, 32'h0, "b2b_alu");
        run_op(1'b1, 1'b1, 1'b0, 32'd1048, 32'h0, 4'd10, 15, 32'hA5A5_0F0F, "ack_last");

        // Reset mid-access, then a stray ack
        wb_en_in = 1'b1; mem_r_en = 1'b1; alu_res = 32'd1052; dest = 4'd11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst mem_req", 32'(mem_req), 0);
        check("midrst wb_en", 32'(wb_en), 0);
        check("midrst mem_err", 32'(mem_err), 0);
        mem_r_en = 1'b0; wb_en_in = 1'b0; alu_res = 32'h0000_0321;
        #1;
        check("midrst ready", 32'(ready), 1);
        model_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFEED_FACE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray mem_req", 32'(mem_req), 0);
            check("stray ready", 32'(ready), 1);
            check("stray wb_en", 32'(wb_en), 0);
            check("stray wb_result", wb_result, 32'h0000_0321);
        end
        mem_ack = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int typ, k;
            logic r, w;
            logic [31:0] a;
            typ = $urandom_range(0, 3);
            r = (typ == 1) || (typ == 3);
            w = (typ >= 2);
            k = $urandom_range(1, 18);
            a = (typ == 0 || $urandom_range(0, 7) == 0) ? $urandom : 32'd1024 + $urandom_range(0, 4095);
            run_op(1'($urandom_range(0, 1)), r, w, a, $urandom, 4'($urandom_range(0, 15)), k,
                   $urandom, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register; sits directly upstream of the register file write port.
- Drives a 32-bit data memory over a req/ack bus.
- Stalls the pipeline through `ready` while an access is in flight.
- Presents wb_result/wb_dest/wb_en, which the register file commits on the following negedge.

Parameters:
ADDR_BASE, 1024, byte address mapped to data-memory word 0
TIMEOUT, 15, ACCESS cycles without mem_ack before the access is abandoned (1..255)

Ports:
clk  in  1  pipeline clock (rising edge)
rst  in  1  reset, asynchronous, active-high
wb_en_in  in  1  instruction writes a register
mem_r_en  in  1  load (LDR)
mem_w_en  in  1  store (STR)
alu_res  in  32  ALU result / byte address
st_val  in  32  store data
dest  in  4  destination register index
ready  out  1  stage can accept/retire; 0 = freeze all upstream stages
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write, registered
mem_addr  out  32  word address, registered
mem_wdata  out  32  write data, registered
mem_ack  in  1  access complete (sampled only in ACCESS)
mem_rdata  in  32  read data, valid with mem_ack
wb_result  out  32  write-back value
wb_dest  out  4  write-back register
wb_en  out  1  write-back enable
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, any state, mid-access included):
  - state=IDLE, counter=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - wb_result=0, wb_dest=0, wb_en=0, mem_err=0.
  - Any outstanding access is dropped; a late mem_ack after reset is ignored.
- mem_op = mem_r_en | mem_w_en. If both are set, treat the op as a read; mem_w_en is ignored.
- Address: mem_addr = {2'b00, (alu_res - ADDR_BASE)[31:2]}, 32-bit wrap-around subtraction. alu_res[1:0] is ignored.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: ready = !mem_op.
    - If mem_op, at the edge go to ACCESS and set mem_req=1, mem_we=(mem_w_en & !mem_r_en), mem_addr, mem_wdata=st_val, counter=0.
    - Otherwise stay in IDLE.
  - ACCESS: ready=0.
    - If mem_ack is sampled at the edge: go to DONE, mem_req<=0, mem_we<=0, latch rdata<=mem_rdata.
    - Else, if counter==TIMEOUT-1: go to DONE, mem_req<=0, rdata<=32'hDEADBEEF, mem_err<=1.
    - Else counter++.
  - DONE: ready=1; at the edge go to IDLE unconditionally.
- MEM/WB register, rising edge:
  - If ready=1: wb_en<=wb_en_in, wb_dest<=dest, wb_result<=(mem_r_en ? rdata : alu_res).
  - If ready=0: wb_en<=0 (bubble); wb_dest and wb_result hold.
- Latency:
  - Non-memory op: 1 cycle, no stall.
  - Access with ack k cycles after mem_req rises (k>=1): ready low for k+1 cycles, result registered at the DONE edge.
- Upstream holds all inputs stable while ready=0. The stage does not re-sample them mid-access.
- mem_ack outside ACCESS is ignored. mem_err clears only on rst.

Test Plan:
- Non-memory op: alu_res=0x1234, dest=3, wb_en_in=1. Required: ready=1 throughout; next cycle wb_result=0x1234, wb_dest=3, wb_en=1; mem_req never asserted.
- Load: alu_res=1032, mem_r_en=1, dest=5; memory acks in the 3rd ACCESS cycle with 0xCAFE0001. Required: mem_addr=2, mem_we=0, mem_req high exactly 3 cycles, ready low 4 cycles, then wb_result=0xCAFE0001, wb_dest=5, wb_en=1 for exactly one cycle.
- Store: alu_res=1028, mem_w_en=1, st_val=0x55AA, wb_en_in=0; ack in the 1st ACCESS cycle. Required: mem_addr=1, mem_we=1, mem_wdata=0x55AA, ready low 2 cycles, wb_en stays 0.
- Timeout: load with mem_ack never asserted. Required: after 15 ACCESS cycles mem_req=0 and mem_err=1; wb_result=0xDEADBEEF; mem_err stays 1 through later ops until rst.
- Reset mid-access: rst pulsed during ACCESS. Required: immediately mem_req=0, wb_en=0, ready=1 in IDLE with no op; a subsequent stray mem_ack produces no write-back.
- Back-to-back: load followed by an ALU op. Required: the ALU op enters on the cycle after DONE; wb_en is high in two distinct cycles with the correct values, and never high during the stall.
